cmd_frame_parser: RTL and testbench

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

---
 rtl/cmd_frame_parser_pkg.sv | 22 ++
 rtl/cmd_frame_parser.sv | 150 +++++++++++++++
 tb/tb_cmd_frame_parser.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frame_parser_pkg.sv
// Shared definitions for the RX command path: frame delimiter, parser state
// encoding and the opcode values understood by the command executor.
package cmd_frame_parser_pkg;

   localparam logic [7:0] SOF = 8'hA5;

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_OPCODE  = 3'd1,
      ST_LEN     = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_CSUM    = 3'd4,
      ST_HOLD    = 3'd5
   } state_e;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_WRITE  = 8'h10;
   localparam logic [7:0] OP_READ   = 8'h20;
   localparam logic [7:0] OP_STATUS = 8'h30;
   localparam logic [7:0] OP_RESET  = 8'h40;

endpackage

// File: rtl/cmd_frame_parser.sv
// Pulls bytes from the RX FIFO, frames SOF/OPCODE/LEN/PAYLOAD/CSUM commands,
// holds each good command until the consumer takes it, and flags bad frames.
module cmd_frame_parser
   import cmd_frame_parser_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD    = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               fifo_rd_data,
   input  logic                     fifo_empty,
   output logic                     fifo_rd_en,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [7:0]               cmd_opcode,
   output logic [3:0]               cmd_len,
   output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
   output logic                     err_csum,
   output logic                     err_len,
   output logic                     err_timeout
);

   localparam int unsigned PW = 8 * MAX_PAYLOAD;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

   state_e          r_state;
   logic [7:0]      r_opcode;
   logic [3:0]      r_len;
   logic [3:0]      r_idx;
   logic [7:0]      r_xor;
   logic [PW-1:0]   r_payload;
   logic [TW-1:0]   r_tcnt;
   logic            r_cmd_valid;
   logic            r_err_csum;
   logic            r_err_len;
   logic            r_err_timeout;

   logic            w_pop;
   logic            w_in_frame;
   logic            w_timeout;

   // The FIFO is drained whenever a byte is available, except while a command waits.
   assign w_pop      = !fifo_empty && (r_state != ST_HOLD);
   assign w_in_frame = (r_state != ST_HUNT) && (r_state != ST_HOLD);
   assign w_timeout  = w_in_frame && !w_pop && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

   assign fifo_rd_en  = w_pop;
   assign cmd_valid   = r_cmd_valid;
   assign cmd_opcode  = r_opcode;
   assign cmd_len     = r_len;
   assign cmd_payload = r_payload;
   assign err_csum    = r_err_csum;
   assign err_len     = r_err_len;
   assign err_timeout = r_err_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_HUNT;
         r_opcode      <= '0;
         r_len         <= '0;
         r_idx         <= '0;
         r_xor         <= '0;
         r_payload     <= '0;
         r_tcnt        <= '0;
         r_cmd_valid   <= 1'b0;
         r_err_csum    <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_err_csum    <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_timeout <= 1'b0;

         // Idle counter only runs inside a frame; any pop restarts it.
         if (w_pop || !w_in_frame || w_timeout) begin
            r_tcnt <= '0;
         end else begin
            r_tcnt <= r_tcnt + TW'(1);
         end

         if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_HUNT;
         end else begin
            case (r_state)
               ST_HUNT: begin
                  if (w_pop && (fifo_rd_data == SOF)) begin
                     r_payload <= '0;
                     r_state   <= ST_OPCODE;
                  end
               end
               ST_OPCODE: begin
                  if (w_pop) begin
                     r_opcode <= fifo_rd_data;
                     r_xor    <= fifo_rd_data;
                     r_state  <= ST_LEN;
                  end
               end
               ST_LEN: begin
                  if (w_pop) begin
                     if (fifo_rd_data > 8'(MAX_PAYLOAD)) begin
                        r_err_len <= 1'b1;
                        r_state   <= ST_HUNT;
                     end else begin
                        r_len   <= fifo_rd_data[3:0];
                        r_xor   <= r_xor ^ fifo_rd_data;
                        r_idx   <= '0;
                        r_state <= (fifo_rd_data == 8'h00) ? ST_CSUM : ST_PAYLOAD;
                     end
                  end
               end
               ST_PAYLOAD: begin
                  if (w_pop) begin
                     for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
                        if (r_idx == 4'(k)) begin
                           r_payload[8*k +: 8] <= fifo_rd_data;
                        end
                     end
                     r_xor <= r_xor ^ fifo_rd_data;
                     r_idx <= r_idx + 4'd1;
                     if (r_idx == (r_len - 4'd1)) begin
                        r_state <= ST_CSUM;
                     end
                  end
               end
               ST_CSUM: begin
                  if (w_pop) begin
                     if (fifo_rd_data == r_xor) begin
                        r_cmd_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                     end else begin
                        r_err_csum <= 1'b1;
                        r_state    <= ST_HUNT;
                     end
                  end
               end
               ST_HOLD: begin
                  if (cmd_ready) begin
                     r_cmd_valid <= 1'b0;
                     r_state     <= ST_HUNT;
                  end
               end
               default: r_state <= ST_HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Scoreboard bench for cmd_frame_parser: a byte-stream reference model predicts
// commands and errors; a monitor compares them against what the parser emits.
module tb_cmd_frame_parser;
   import cmd_frame_parser_pkg::*;

   localparam int unsigned MAXP      = 8;
   localparam int unsigned TMO       = 1000;
   localparam int unsigned PW        = 8 * MAXP;
   localparam int          EXP_DEPTH = 512;

   typedef enum int { EV_CMD = 0, EV_CSUM = 1, EV_LEN = 2, EV_TMO = 3 } ev_kind_e;
   typedef struct {
      ev_kind_e      kind;
      logic [7:0]    op;
      logic [3:0]    len;
      logic [PW-1:0] pl;
   } ev_t;
   typedef struct {
      logic [7:0]  b;
      int unsigned gap;
   } fb_t;

   logic          clk          = 1'b0;
   logic          rst_n        = 1'b0;
   logic [7:0]    fifo_rd_data = 8'h00;
   logic          fifo_empty   = 1'b1;
   logic          cmd_ready    = 1'b0;
   logic          fifo_rd_en;
   logic          cmd_valid;
   logic [7:0]    cmd_opcode;
   logic [3:0]    cmd_len;
   logic [PW-1:0] cmd_payload;
   logic          err_csum;
   logic          err_len;
   logic          err_timeout;

   fb_t fifo_q[$];
   ev_t exp_arr[EXP_DEPTH];
   int  exp_wr     = 0;
   int  exp_rd     = 0;
   int  errors     = 0;
   int  checks     = 0;
   int  ready_mode = 2;
   bit  done       = 1'b0;
   bit  stuck      = 1'b0;

   cmd_frame_parser #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_rd_data (fifo_rd_data),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_opcode   (cmd_opcode),
      .cmd_len      (cmd_len),
      .cmd_payload  (cmd_payload),
      .err_csum     (err_csum),
      .err_len      (err_len),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic fb_t fb(input logic [7:0] b, input int unsigned g);
      fb_t e;
      e.b   = b;
      e.gap = g;
      return e;
   endfunction

   function automatic int unsigned rgap();
      return ($urandom_range(3) == 0) ? $urandom_range(4) : 0;
   endfunction

   // A byte is usable by a frame only if it arrives before the idle limit.
   function automatic bit avail(input fb_t s[$], input int i);
      return (i < s.size()) && (s[i].gap < TMO);
   endfunction

   task automatic push_exp(input ev_kind_e k, input logic [7:0] op, input logic [3:0] len,
                           input logic [PW-1:0] pl);
      if (exp_wr < EXP_DEPTH) begin
         exp_arr[exp_wr].kind = k;
         exp_arr[exp_wr].op   = op;
         exp_arr[exp_wr].len  = len;
         exp_arr[exp_wr].pl   = pl;
         exp_wr++;
      end
   endtask

   // Reference model: walk a segment (starting in hunt) and list the outcomes.
   task automatic model(input fb_t s[$]);
      int            i = 0;
      logic [7:0]    op, ln, x;
      logic [PW-1:0] pl;
      bit            ok;
      while (i < s.size()) begin
         if (s[i].b != SOF) begin
            i++;
            continue;
         end
         i++;
         if (!avail(s, i)) begin push_exp(EV_TMO, 8'h00, 4'h0, '0); continue; end
         op = s[i].b;
         i++;
         if (!avail(s, i)) begin push_exp(EV_TMO, 8'h00, 4'h0, '0); continue; end
         ln = s[i].b;
         i++;
         if (ln > 8'(MAXP)) begin push_exp(EV_LEN, 8'h00, 4'h0, '0); continue; end
         x  = op ^ ln;
         pl = '0;
         ok = 1'b1;
         for (int k = 0; k < int'(ln); k++) begin
            if (!avail(s, i)) begin ok = 1'b0; break; end
            pl[8*k +: 8] = s[i].b;
            x = x ^ s[i].b;
            i++;
         end
         if (!ok || !avail(s, i)) begin push_exp(EV_TMO, 8'h00, 4'h0, '0); continue; end
         if (s[i].b == x) push_exp(EV_CMD, op, ln[3:0], pl);
         else             push_exp(EV_CSUM, 8'h00, 4'h0, '0);
         i++;
      end
   endtask

   task automatic send(input fb_t s[$]);
      model(s);
      foreach (s[k]) fifo_q.push_back(s[k]);
   endtask

   task automatic send_bytes(input logic [7:0] b[$]);
      fb_t s[$];
      foreach (b[k]) s.push_back(fb(b[k], 0));
      send(s);
   endtask

   // One clock: record the pop the parser made, then present the next FIFO head.
   task automatic cycle();
      @(posedge clk);
      if (rst_n && fifo_rd_en && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
      @(negedge clk);
      if (fifo_q.size() == 0) begin
         fifo_empty   = 1'b1;
         fifo_rd_data = 8'($urandom);
      end else if (fifo_q[0].gap > 0) begin
         fifo_q[0].gap = fifo_q[0].gap - 1;
         fifo_empty    = 1'b1;
         fifo_rd_data  = 8'($urandom);
      end else begin
         fifo_empty   = 1'b0;
         fifo_rd_data = fifo_q[0].b;
      end
   endtask

   task automatic drain(input int budget);
      for (int k = 0; k < budget; k++) begin
         if ((fifo_q.size() == 0) && (exp_rd == exp_wr)) break;
         cycle();
      end
      if ((fifo_q.size() != 0) || (exp_rd != exp_wr)) stuck = 1'b1;
   endtask

   task automatic gen_random();
      fb_t        s[$];
      int         t;
      int         n;
      logic [7:0] op, x, v;
      t = $urandom_range(5);
      if (t == 0) begin
         n = $urandom_range(3, 1);
         for (int k = 0; k < n; k++) begin
            do v = 8'($urandom); while (v == SOF);
            s.push_back(fb(v, rgap()));
         end
      end else begin
         op = 8'($urandom);
         if (t == 4)      n = $urandom_range(255, MAXP + 1);
         else if (t == 5) n = 0;
         else             n = $urandom_range(MAXP);
         s.push_back(fb(SOF, rgap()));
         s.push_back(fb(op, rgap()));
         s.push_back(fb(8'(n), rgap()));
         x = op ^ 8'(n);
         if (t != 4) begin
            for (int k = 0; k < n; k++) begin
               v = ($urandom_range(4) == 0) ? SOF : 8'($urandom);
               x = x ^ v;
               s.push_back(fb(v, rgap()));
            end
            if (t == 3) x = x ^ 8'($urandom_range(255, 1));
            s.push_back(fb(x, rgap()));
         end
      end
      send(s);
   endtask

   // Stimulus
   initial begin
      logic [7:0] bq[$];
      fb_t        s[$];
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (2) cycle();

      bq = '{SOF, OP_WRITE, 8'h02, 8'h11, 8'h22, 8'h21}; send_bytes(bq);
      bq = '{8'h00, 8'hFF, SOF, OP_READ, 8'h00, 8'h20};  send_bytes(bq);
      bq = '{SOF, OP_WRITE, 8'h02, 8'h11, 8'h22, 8'h00}; send_bytes(bq);
      bq = '{SOF, OP_WRITE, 8'h02, 8'h11, 8'h22, 8'h21}; send_bytes(bq);
      bq = '{SOF, OP_WRITE, 8'h09};                      send_bytes(bq);
      bq = '{SOF, OP_STATUS, 8'h01, SOF, 8'h94};         send_bytes(bq);
      drain(300);

      // Idle-limit boundaries: long stall, exactly the limit, one short of it.
      s = {};
      s.push_back(fb(SOF, 0));  s.push_back(fb(OP_WRITE, 0)); s.push_back(fb(8'h02, 1200));
      s.push_back(fb(SOF, 0));  s.push_back(fb(OP_READ, 0));  s.push_back(fb(8'h00, TMO));
      s.push_back(fb(SOF, 0));  s.push_back(fb(OP_WRITE, 0)); s.push_back(fb(8'h02, TMO - 1));
      s.push_back(fb(8'h11, 0)); s.push_back(fb(8'h22, 0));   s.push_back(fb(8'h21, 0));
      send(s);
      drain(4000);

      // Consumer stalls with more frames queued behind the held command.
      ready_mode = 1;
      bq = '{SOF, OP_NOP, 8'h01, 8'h7E, 8'h7F};          send_bytes(bq);
      bq = '{SOF, OP_READ, 8'h00, 8'h20};                send_bytes(bq);
      for (int k = 0; k < 100; k++) begin
         if (cmd_valid) break;
         cycle();
      end
      if (!cmd_valid) stuck = 1'b1;
      repeat (50) cycle();
      ready_mode = 2;
      drain(300);

      // Reset in the middle of a payload abandons the frame silently.
      bq = '{SOF, OP_RESET, 8'h04, 8'h01, 8'h02};
      foreach (bq[k]) fifo_q.push_back(fb(bq[k], 0));
      for (int k = 0; k < 50; k++) begin
         if (fifo_q.size() == 0) break;
         cycle();
      end
      repeat (2) cycle();
      rst_n = 1'b0;
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (2) cycle();
      bq = '{SOF, OP_WRITE, 8'h02, 8'h11, 8'h22, 8'h21}; send_bytes(bq);
      drain(300);

      ready_mode = 0;
      for (int k = 0; k < 80; k++) gen_random();
      drain(20000);
      done = 1'b1;
      repeat (5) cycle();
   end

   // Monitor / scoreboard
   initial begin
      logic [7:0]    snap_op;
      logic [3:0]    snap_len;
      logic [PW-1:0] snap_pl;
      bit            held;
      int            nerr;
      ev_kind_e      kind;
      ev_t           e;
      held = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         cmd_ready = (ready_mode == 1) ? 1'b0 :
                     (ready_mode == 2) ? 1'b1 : ($urandom_range(3) != 0);
         if (done) begin
            checks++;
            if (stuck || (exp_rd != exp_wr) || (fifo_q.size() != 0)) begin
               errors++;
               $display("FAIL drain: pending_events=%0d fifo_bytes=%0d stuck=%0d, expected 0 0 0",
                        exp_wr - exp_rd, fifo_q.size(), stuck);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end else if (!rst_n) begin
            held = 1'b0;
            checks++;
            if (cmd_valid || err_csum || err_len || err_timeout || (cmd_opcode != 8'h00) ||
                (cmd_len != 4'h0) || (cmd_payload != '0) || (fifo_rd_en !== !fifo_empty)) begin
               errors++;
               $display("FAIL reset_state: valid=%b errs=%b%b%b op=%h len=%0d pl=%h rd_en=%b, expected all zero rd_en=%b",
                        cmd_valid, err_csum, err_len, err_timeout, cmd_opcode, cmd_len,
                        cmd_payload, fifo_rd_en, !fifo_empty);
            end
         end else begin
            nerr = int'(err_csum) + int'(err_len) + int'(err_timeout);
            if (nerr > 1) begin
               checks++;
               errors++;
               $display("FAIL err_exclusive: got csum=%b len=%b timeout=%b, expected at most one",
                        err_csum, err_len, err_timeout);
            end else if (nerr == 1) begin
               kind = err_csum ? EV_CSUM : (err_len ? EV_LEN : EV_TMO);
               checks++;
               if (exp_rd >= exp_wr) begin
                  errors++;
                  $display("FAIL unexpected_error: got kind=%0d, expected no event", int'(kind));
               end else begin
                  e = exp_arr[exp_rd];
                  exp_rd++;
                  if (e.kind != kind) begin
                     errors++;
                     $display("FAIL error_kind: got kind=%0d, expected kind=%0d", int'(kind), int'(e.kind));
                  end
               end
            end
            if (cmd_valid) begin
               checks++;
               if (fifo_rd_en) begin
                  errors++;
                  $display("FAIL hold_no_pop: got fifo_rd_en=1, expected 0 while cmd_valid");
               end
               if (!held) begin
                  snap_op  = cmd_opcode;
                  snap_len = cmd_len;
                  snap_pl  = cmd_payload;
                  held     = 1'b1;
               end
               if (cmd_ready) begin
                  held = 1'b0;
                  checks++;
                  if ((snap_op != cmd_opcode) || (snap_len != cmd_len) || (snap_pl != cmd_payload)) begin
                     errors++;
                     $display("FAIL hold_stable: got op=%h len=%0d pl=%h, expected op=%h len=%0d pl=%h",
                              cmd_opcode, cmd_len, cmd_payload, snap_op, snap_len, snap_pl);
                  end
                  checks++;
                  if (exp_rd >= exp_wr) begin
                     errors++;
                     $display("FAIL unexpected_cmd: got op=%h len=%0d, expected no event", cmd_opcode, cmd_len);
                  end else begin
                     e = exp_arr[exp_rd];
                     exp_rd++;
                     if ((e.kind != EV_CMD) || (e.op != cmd_opcode) || (e.len != cmd_len) || (e.pl != cmd_payload)) begin
                        errors++;
                        $display("FAIL cmd: got kind=0 op=%h len=%0d pl=%h, expected kind=%0d op=%h len=%0d pl=%h",
                                 cmd_opcode, cmd_len, cmd_payload, int'(e.kind), e.op, e.len, e.pl);
                     end
                  end
               end
            end else begin
               held = 1'b0;
            end
         end
      end
   end

endmodule
